// File: rtl/rr_arb_stage.sv
// rr_arb_stage: N-way round-robin arbiter followed by a registered output slice.
//   Each cycle one valid requester is picked by circular scan from the priority
//   pointer. The winning payload, and its one-hot grant, are loaded into a
//   valid/ready output register. The slice accepts a new entry whenever it is
//   empty or is being drained, so back-to-back transfers run at full rate.
//
// Optional feature (compile-time macro RR_ARB_STAGE_LOCK_EN):
//   Packet lock. A beat with req_last_i clear holds the grant on that requester
//   until the beat that carries req_last_i. Without the macro, req_last_i is
//   ignored and every transfer is single-beat.
//
// Ports:
//   clk         clock, rising edge
//   arst_n      asynchronous active-low reset
//   req_vld_i   [N]   per-requester valid
//   req_dat_i   [N*W] packed payloads, requester i at [W*i +: W]
//   req_last_i  [N]   end-of-packet marker (lock build only)
//   req_rdy_o   [N]   per-requester ready, one-hot or zero (combinational)
//   out_vld_o         output slice holds a valid entry
//   out_dat_o   [W]   registered winning payload
//   out_gnt_o   [N]   registered one-hot source of out_dat_o
//   out_rdy_i         downstream ready
module rr_arb_stage #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [N-1:0]   req_vld_i,
  input  logic [N*W-1:0] req_dat_i,
  input  logic [N-1:0]   req_last_i,
  output logic [N-1:0]   req_rdy_o,
  output logic           out_vld_o,
  output logic [W-1:0]   out_dat_o,
  output logic [N-1:0]   out_gnt_o,
  input  logic           out_rdy_i
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     rr_gnt_c;
  logic [IDX_W-1:0] rr_idx_c;
  logic [N-1:0]     gnt_c;
  logic [IDX_W-1:0] win_idx_c;
  logic             accept_c;
  logic             xfer_c;
  logic [W-1:0]     mux_dat_c;
  logic             locked_c;
  logic [IDX_W-1:0] lock_idx_c;
  logic             lock_hold_c;

  logic             out_vld_q;
  logic [W-1:0]     out_dat_q;
  logic [N-1:0]     out_gnt_q;

  // Circular scan: first valid requester at or after the pointer.
  always_comb begin : rr_scan
    logic        found;
    int unsigned idx;
    found    = 1'b0;
    idx      = 0;
    rr_gnt_c = '0;
    rr_idx_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req_vld_i[idx]) begin
        found         = 1'b1;
        rr_gnt_c[idx] = 1'b1;
        rr_idx_c      = IDX_W'(idx);
      end
    end
  end

  // A held packet overrides the round-robin choice.
  always_comb begin : gnt_sel
    gnt_c     = rr_gnt_c;
    win_idx_c = rr_idx_c;
    if (locked_c) begin
      gnt_c     = N'(1) << lock_idx_c;
      win_idx_c = lock_idx_c;
    end
  end

  // Ready is forced low while reset is held, even though the slice is empty.
  assign accept_c  = ~out_vld_q | out_rdy_i;
  assign req_rdy_o = gnt_c & req_vld_i & {N{accept_c & arst_n}};
  assign xfer_c    = |req_rdy_o;

  // One-hot AND-OR payload selector.
  always_comb begin : dat_mux
    mux_dat_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_c[i]) begin
        mux_dat_c = mux_dat_c | req_dat_i[W*i +: W];
      end
    end
  end

  // Pointer moves past the winner, except while a packet keeps the lock.
  always_comb begin : ptr_next
    ptr_d = ptr_q;
    if (xfer_c && !lock_hold_c) begin
      ptr_d = (win_idx_c == IDX_W'(N - 1)) ? '0 : win_idx_c + IDX_W'(1);
    end
  end

`ifdef RR_ARB_STAGE_LOCK_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  // Lock FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Lock FSM next state: a non-last beat opens a packet, a last beat closes it.
  always_comb begin : lock_next
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_c && !req_last_i[win_idx_c]) begin
          state_d    = ST_LOCKED;
          lock_idx_d = win_idx_c;
        end
      end
      ST_LOCKED: begin
        if (xfer_c && req_last_i[lock_idx_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lock FSM outputs.
  always_comb begin : lock_out
    locked_c    = (state_q == ST_LOCKED);
    lock_idx_c  = lock_idx_q;
    lock_hold_c = (state_d == ST_LOCKED);
  end
`else
  logic unused_last;

  assign locked_c    = 1'b0;
  assign lock_idx_c  = '0;
  assign lock_hold_c = 1'b0;
  assign unused_last = ^req_last_i;
`endif

  // Output slice and priority pointer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_gnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer_c) begin
        out_vld_q <= 1'b1;
        out_dat_q <= mux_dat_c;
        out_gnt_q <= gnt_c;
      end else if (out_rdy_i) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;
  assign out_gnt_o = out_gnt_q;

endmodule

// File: tb/tb_rr_arb_stage.sv
// Bench for rr_arb_stage (N=4, W=8): directed scenarios plus random traffic,
// all checked against a transaction-level model kept in the bench.
module tb_rr_arb_stage;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [N-1:0] vld;
  logic [N-1:0] last;
  logic [W-1:0] dat [N];
  logic [N*W-1:0] dat_bus;
  logic         ordy;
  logic [N-1:0] rdy_o;
  logic         ovld;
  logic [W-1:0] odat;
  logic [N-1:0] gnt_o;

  int total = 0;
  int bad   = 0;

  // Model state: priority index, output entry, packet lock.
  int           m_ptr;
  bit           m_vld;
  logic [W-1:0] m_dat;
  logic [N-1:0] m_gnt;
  bit           m_lock;
  int           m_lock_i;

  always #5 clk = ~clk;

  assign dat_bus = {dat[3], dat[2], dat[1], dat[0]};

  rr_arb_stage #(.N(N), .W(W)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_vld_i  (vld),
    .req_dat_i  (dat_bus),
    .req_last_i (last),
    .req_rdy_o  (rdy_o),
    .out_vld_o  (ovld),
    .out_dat_o  (odat),
    .out_gnt_o  (gnt_o),
    .out_rdy_i  (ordy)
  );

  task automatic model_reset();
    m_ptr    = 0;
    m_vld    = 1'b0;
    m_dat    = '0;
    m_gnt    = '0;
    m_lock   = 1'b0;
    m_lock_i = 0;
  endtask

  // Ready the spec demands for the current inputs and model state.
  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] g;
    bit           found;
    int           i;
    g = '0;
    found = 1'b0;
    if (m_lock) begin
      g[m_lock_i] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && vld[i]) begin
          g[i]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    if (!arst_n || (m_vld && !ordy)) return '0;
    return g & vld;
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    logic [N-1:0] r;
    int           w;
    r = exp_rdy();
    w = 0;
    for (int j = 0; j < N; j++) if (r[j]) w = j;
    @(posedge clk);
    if (r != '0) begin
      m_vld = 1'b1;
      m_dat = dat[w];
      m_gnt = r;
`ifdef RR_ARB_STAGE_LOCK_EN
      if (!m_lock) begin
        if (!last[w]) begin
          m_lock   = 1'b1;
          m_lock_i = w;
        end else begin
          m_ptr = (w + 1) % N;
        end
      end else if (last[w]) begin
        m_lock = 1'b0;
        m_ptr  = (w + 1) % N;
      end
`else
      m_ptr = (w + 1) % N;
`endif
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    vld    = 4'b1111;
    last   = 4'b1111;
    ordy   = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = 8'h10 + 8'(i);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rdy_o !== 4'b0000 || ovld !== 1'b0 || odat !== 8'h00 || gnt_o !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold rdy=%b vld=%b dat=%h gnt=%b want 0000/0/00/0000",
               rdy_o, ovld, odat, gnt_o);
    end
    vld    = 4'b0000;
    arst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (rdy_o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle_rdy c=%0d got=%b exp=0000", c, rdy_o);
      end
      tick();
      total++;
      if (ovld !== 1'b0 || gnt_o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle_out c=%0d vld=%b gnt=%b exp 0/0000", c, ovld, gnt_o);
      end
    end
  endtask

  task automatic test_rotation();
    vld  = 4'b1111;
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (rdy_o !== 4'(1 << (c % 4))) begin
        bad++;
        $display("FAIL rot_rdy c=%0d got=%b exp=%b", c, rdy_o, 4'(1 << (c % 4)));
      end
      tick();
      total++;
      if (ovld !== 1'b1 || odat !== 8'h10 + 8'(c % 4)) begin
        bad++;
        $display("FAIL rot_out c=%0d vld=%b dat=%h exp 1/%h", c, ovld, odat, 8'h10 + 8'(c % 4));
      end
    end
  endtask

  task automatic test_stall();
    vld  = 4'b1111;
    ordy = 1'b1;
    tick();
    tick();
    total++;
    if (odat !== 8'h11 || gnt_o !== 4'b0010) begin
      bad++;
      $display("FAIL stall_setup dat=%h gnt=%b exp 11/0010", odat, gnt_o);
    end
    ordy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rdy_o !== 4'b0000) begin
        bad++;
        $display("FAIL stall_rdy c=%0d got=%b exp=0000", c, rdy_o);
      end
      tick();
      total++;
      if (ovld !== 1'b1 || odat !== 8'h11 || gnt_o !== 4'b0010) begin
        bad++;
        $display("FAIL stall_hold c=%0d vld=%b dat=%h gnt=%b exp 1/11/0010", c, ovld, odat, gnt_o);
      end
    end
    ordy = 1'b1;
    #1;
    total++;
    if (rdy_o !== 4'b0100) begin
      bad++;
      $display("FAIL stall_release_rdy got=%b exp=0100", rdy_o);
    end
    tick();
    total++;
    if (odat !== 8'h12 || gnt_o !== 4'b0100) begin
      bad++;
      $display("FAIL stall_release_out dat=%h gnt=%b exp 12/0100", odat, gnt_o);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] seq [3];
    seq[0] = 4'b1000;
    seq[1] = 4'b0001;
    seq[2] = 4'b1000;
    ordy = 1'b1;
    vld  = 4'b0001;
    tick();
    total++;
    if (gnt_o !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_setup gnt=%b exp=0001", gnt_o);
    end
    vld = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (gnt_o !== seq[c] || ovld !== 1'b1) begin
        bad++;
        $display("FAIL wrap_gnt c=%0d gnt=%b vld=%b exp %b/1", c, gnt_o, ovld, seq[c]);
      end
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] seq [5];
    int           n;
    int           beat;
    bit           took2;
`ifdef RR_ARB_STAGE_LOCK_EN
    seq[0] = 8'hA0; seq[1] = 8'hA1; seq[2] = 8'hA2; seq[3] = 8'h50; seq[4] = 8'h00;
    n = 4;
`else
    seq[0] = 8'hA0; seq[1] = 8'h50; seq[2] = 8'hA1; seq[3] = 8'h50; seq[4] = 8'hA2;
    n = 5;
`endif
    ordy = 1'b1;
    last = 4'b1111;
    vld  = 4'b0010;
    tick();
    dat[0] = 8'h50;
    dat[2] = 8'hA0;
    last   = 4'b1011;
    vld    = 4'b0101;
    beat   = 0;
    for (int c = 0; c < n; c++) begin
      #1;
      took2 = rdy_o[2];
      tick();
      total++;
      if (odat !== seq[c] || ovld !== 1'b1) begin
        bad++;
        $display("FAIL lock_seq c=%0d dat=%h vld=%b exp %h/1", c, odat, ovld, seq[c]);
      end
      if (took2) begin
        beat++;
        dat[2]  = 8'hA0 + 8'(beat);
        last[2] = (beat == 2);
        if (beat == 3) vld[2] = 1'b0;
      end
    end
    last = 4'b1111;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      vld  = 4'($urandom);
      last = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (rdy_o !== exp_rdy()) begin
        bad++;
        $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, rdy_o, exp_rdy());
      end
      tick();
      total++;
      if (ovld !== m_vld || (m_vld && (odat !== m_dat || gnt_o !== m_gnt))) begin
        bad++;
        $display("FAIL rand_out c=%0d vld=%b dat=%h gnt=%b exp %b/%h/%b",
                 c, ovld, odat, gnt_o, m_vld, m_dat, m_gnt);
      end
    end
    // Close any open packet so the next scenario starts unlocked.
    last = 4'b1111;
    vld  = 4'b1111;
    ordy = 1'b1;
    tick();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < N; i++) dat[i] = 8'h30 + 8'(i);
    vld  = 4'b1111;
    last = 4'b1111;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    tick();
    total++;
    if (ovld !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre vld=%b exp=1", ovld);
    end
    arst_n = 1'b0;
    #1;
    total++;
    if (ovld !== 1'b0 || rdy_o !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_async vld=%b rdy=%b exp 0/0000", ovld, rdy_o);
    end
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    ordy   = 1'b1;
    #1;
    total++;
    if (rdy_o !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_first_rdy got=%b exp=0001", rdy_o);
    end
    tick();
    total++;
    if (gnt_o !== 4'b0001 || odat !== 8'h30 || ovld !== 1'b1) begin
      bad++;
      $display("FAIL midrst_first_out gnt=%b dat=%h vld=%b exp 0001/30/1", gnt_o, odat, ovld);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_wrap();
    test_lock();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
